fetch_2_aligner: RTL
====================

# fetch_2_aligner

Second fetch stage. Captures the even and odd 16-byte I$ lines produced by fetch stage 1 into two line latches, tracks a byte pointer across the two-line window, and presents a 16-byte instruction packet aligned to the current instruction to decode. It returns per-bank load pulses upstream so stage 1 advances its even/odd FIP registers.

## Interface

Parameters: none.

Ports:
- `clk`  in  1  single clock, all state on rising edge
- `reset`  in  1  asynchronous, active-low; clears all state
- `even_line_in`  in  128  even-bank line from stage 1, byte 0 = bits [7:0]
- `odd_line_in`  in  128  odd-bank line from stage 1
- `cache_miss_even`  in  1  1 = `even_line_in` not usable this cycle
- `cache_miss_odd`  in  1  1 = `odd_line_in` not usable this cycle
- `FIP_e_lsb`  in  2  line-address bits [5:4] of the presented even line
- `FIP_o_lsb`  in  2  line-address bits [5:4] of the presented odd line
- `is_resteer`  in  1  control-flow redirect this cycle
- `resteer_addr`  in  5  target byte address bits [4:0]; bit 4 = bank (0 even, 1 odd)
- `decode_consume`  in  1  decode accepts the packet this cycle
- `consume_len`  in  5  bytes consumed, legal 1..16
- `packet_out`  out  128  16 bytes starting at pointer, byte 0 = bits [7:0]
- `packet_valid`  out  1  packet fully backed by valid lines
- `cur_line_tag`  out  2  stored lsb tag of the current-bank line
- `even_latch_was_loaded`  out  1  even latch captured a line this cycle
- `odd_latch_was_loaded`  out  1  odd latch captured a line this cycle

## Operation

- State: `line_e`, `line_o` (128 b), `tag_e`, `tag_o` (2 b), `v_e`, `v_o`, `ptr` (5 b). `ptr[4]` = current bank; `ptr[3:0]` = byte offset within it. The next bank is the other bank.
- Window: 32 bytes = {next line, current line}. `packet_out` byte i = window byte (`ptr[3:0]` + i), i = 0..15. Combinational from registers.
- `packet_valid` = `v_e` & `v_o`.
- `cur_line_tag` = `ptr[4]` ? `tag_o` : `tag_e`.
- Normal load (no resteer): bank x loads when `v_x`=0 and `cache_miss_x`=0. It sets `v_x`, captures the line and lsb, and pulses `x_latch_was_loaded` combinationally the same cycle.
- Consume: takes effect only when `decode_consume` & `packet_valid`, otherwise ignored.
  - len 0: no-op.
  - len 17..31: treated as 16.
  - sum = `ptr[3:0]` + len (5-bit).
  - If sum[4]=0: `ptr[3:0]` <= sum[3:0].
  - If sum[4]=1: current bank retires (its valid bit cleared), `ptr[4]` toggles, `ptr[3:0]` <= sum[3:0].
  - At most one retirement per cycle (max sum 31).
- Retire and load of the same bank never coincide: loading requires valid=0 at the edge. The retired bank refills no earlier than the following cycle.
- Resteer has priority over consume and normal load:
  - `ptr` <= `resteer_addr`.
  - For each bank: `v_x` <= ~`cache_miss_x`, line and tag captured.
  - `x_latch_was_loaded` = ~`cache_miss_x`.
  - Any concurrent consume is discarded.
- During reset low, both load pulses are forced to 0.

## Timing

- Reset values: `v_e`=`v_o`=0, `ptr`=0, lines=0, tags=0. Therefore `packet_out`=0, `packet_valid`=0, `cur_line_tag`=0, both load pulses 0.
- After reset release with both miss inputs low: cycle 0 both load pulses = 1; cycle 1 `packet_valid`=1.
- Load pulses are Mealy outputs: same cycle as the capture edge, so stage 1 loads its FIP register on that edge.
- Consume that retires a line: next cycle `packet_valid`=0. Earliest refill is the cycle after, so the minimum bubble is one cycle.
- Resteer with both hits: `packet_valid`=1 the next cycle, packet starts at `resteer_addr[3:0]` of bank `resteer_addr[4]`.
- A miss held high keeps that bank invalid and its pulse 0 indefinitely. No timeout.
- Reset asserted mid-operation clears state immediately, independent of `clk`.

## Test plan

- **Reset/fill:** hold `reset` low, check all outputs 0. Release with even=0x0F..00, odd=0x1F..10, no misses.
  - Cycle 0: both pulses 1.
  - Cycle 1: `packet_valid`=1, `packet_out`=0x0F0E..00.
- **Intra-line consume:** from the filled state, consume len 3.
  - `ptr`=0x03, packet byte 0 = 0x03, byte 15 = 0x12, no pulses.
- **Line crossing:**
  - From ptr 0x0E, consume len 5: `ptr`=0x13, `v_e`=0, `packet_valid`=0 next cycle.
  - Following cycle: even pulse=1.
  - Cycle after that: packet byte 0 = odd byte 3.
- **Full-line consume:** from ptr 0x00, len 16 → `ptr`=0x10, even retired. Repeat with len 0 → no state change. Repeat with len 20 → same result as len 16.
- **Resteer:** `is_resteer` with `resteer_addr`=0x1A, `cache_miss_even`=1, `decode_consume`=1, len 4.
  - Consume ignored; `ptr`=0x1A, odd pulse=1, even pulse=0, `packet_valid`=0.
  - Clear the miss: even pulse next cycle, then packet byte 0 = odd byte 10.
- **Async reset mid-stream:** drop `reset` between clock edges while `packet_valid`=1. All outputs 0 before the next `clk` edge.

Source files
------------

// File: rtl/fetch_2_aligner.sv
// Second fetch stage: latches the even/odd I$ lines and presents a
// 16-byte packet aligned to the current instruction byte pointer.
module fetch_2_aligner (
  input  logic         clk,
  input  logic         reset,
  input  logic [127:0] even_line_in,
  input  logic [127:0] odd_line_in,
  input  logic         cache_miss_even,
  input  logic         cache_miss_odd,
  input  logic [1:0]   FIP_e_lsb,
  input  logic [1:0]   FIP_o_lsb,
  input  logic         is_resteer,
  input  logic [4:0]   resteer_addr,
  input  logic         decode_consume,
  input  logic [4:0]   consume_len,
  output logic [127:0] packet_out,
  output logic         packet_valid,
  output logic [1:0]   cur_line_tag,
  output logic         even_latch_was_loaded,
  output logic         odd_latch_was_loaded
);

  logic [127:0] line_e_q, line_e_d;
  logic [127:0] line_o_q, line_o_d;
  logic [1:0]   tag_e_q, tag_e_d;
  logic [1:0]   tag_o_q, tag_o_d;
  logic         v_e_q, v_e_d;
  logic         v_o_q, v_o_d;
  logic [4:0]   ptr_q, ptr_d;

  logic         ld_e, ld_o;
  logic         cons;
  logic [4:0]   len_eff;
  logic [4:0]   sum;
  logic [255:0] window;
  logic [7:0]   sh;

  assign packet_valid = v_e_q & v_o_q;
  assign cur_line_tag = ptr_q[4] ? tag_o_q : tag_e_q;

  // Window is {next line, current line}; bank ptr_q[4] is current.
  assign window = ptr_q[4] ? {line_e_q, line_o_q}
                           : {line_o_q, line_e_q};
  assign sh         = {1'b0, ptr_q[3:0], 3'b000};
  assign packet_out = window[sh +: 128];

  always_comb begin
    ld_e = 1'b0;
    ld_o = 1'b0;
    if (reset) begin
      if (is_resteer) begin
        ld_e = ~cache_miss_even;
        ld_o = ~cache_miss_odd;
      end else begin
        ld_e = ~v_e_q & ~cache_miss_even;
        ld_o = ~v_o_q & ~cache_miss_odd;
      end
    end
  end

  assign even_latch_was_loaded = ld_e;
  assign odd_latch_was_loaded  = ld_o;

  // Lengths 16..31 all clamp to a full line.
  assign len_eff = consume_len[4] ? 5'd16 : consume_len;
  assign sum     = {1'b0, ptr_q[3:0]} + len_eff;
  assign cons    = decode_consume & packet_valid & ~is_resteer
                 & (consume_len != 5'd0);

  always_comb begin
    line_e_d = line_e_q;
    line_o_d = line_o_q;
    tag_e_d  = tag_e_q;
    tag_o_d  = tag_o_q;
    v_e_d    = v_e_q;
    v_o_d    = v_o_q;
    ptr_d    = ptr_q;
    if (is_resteer) begin
      ptr_d = resteer_addr;
      v_e_d = ~cache_miss_even;
      v_o_d = ~cache_miss_odd;
    end else if (cons) begin
      ptr_d = {ptr_q[4] ^ sum[4], sum[3:0]};
      if (sum[4]) begin
        if (ptr_q[4]) v_o_d = 1'b0;
        else          v_e_d = 1'b0;
      end
    end
    // A bank loads only while invalid, so it never collides with retire.
    if (ld_e) begin
      line_e_d = even_line_in;
      tag_e_d  = FIP_e_lsb;
      v_e_d    = 1'b1;
    end
    if (ld_o) begin
      line_o_d = odd_line_in;
      tag_o_d  = FIP_o_lsb;
      v_o_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      line_e_q <= '0;
      line_o_q <= '0;
      tag_e_q  <= '0;
      tag_o_q  <= '0;
      v_e_q    <= 1'b0;
      v_o_q    <= 1'b0;
      ptr_q    <= '0;
    end else begin
      line_e_q <= line_e_d;
      line_o_q <= line_o_d;
      tag_e_q  <= tag_e_d;
      tag_o_q  <= tag_o_d;
      v_e_q    <= v_e_d;
      v_o_q    <= v_o_d;
      ptr_q    <= ptr_d;
    end
  end

endmodule
